// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment reader.
// Segment patterns are ordered {a,b,c,d,e,f,g} with a as the MSB and are
// active-high. The FSM state type and the error digit code also live here.
package seg7_pkg;

  // Segment patterns for the decimal digits
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  // Some panels draw 9 without the bottom segment
  localparam logic [6:0] SEG_9_ALT = 7'b1110011;

  // Value reported for any pattern that is not a known digit
  localparam logic [3:0] DIGIT_ERR = 4'hF;

  // Capture FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  // True when exactly one bit of the digit strobe is set
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Index of the set bit of a one-hot strobe (0 for illegal codes)
  function automatic logic [1:0] one_hot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_dec.sv
// seg7_pattern_dec: purely combinational lookup of an active-high
// {a..g} segment pattern to its BCD value. Unknown patterns give DIGIT_ERR
// with o_err set. Kept standalone so the display side can reuse it.
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_value,
  output logic       o_err
);

  // Pattern table lookup
  always_comb begin
    o_value = DIGIT_ERR;
    o_err   = 1'b0;
    case (i_pattern)
      SEG_0:     o_value = 4'd0;
      SEG_1:     o_value = 4'd1;
      SEG_2:     o_value = 4'd2;
      SEG_3:     o_value = 4'd3;
      SEG_4:     o_value = 4'd4;
      SEG_5:     o_value = 4'd5;
      SEG_6:     o_value = 4'd6;
      SEG_7:     o_value = 4'd7;
      SEG_8:     o_value = 4'd8;
      SEG_9:     o_value = 4'd9;
      SEG_9_ALT: o_value = 4'd9;
      default: begin
        o_value = DIGIT_ERR;
        o_err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: snoops a multiplexed 7-segment display and reports each
// stable digit presentation exactly once through a valid/ready handshake.
// Build option: define SEG7_RD_ACTIVE_LOW_EN for common-anode panels whose
// segment lines are active-low; seg_in is then inverted ahead of sampling.
//
// Latency: the edge that first loads a new {dig_sel, seg_in} into the
// sample register is cycle 0; valid rises on edge STABLE_CYCLES+1 when the
// FSM starts from IDLE.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic [3:0] dig_sel,
  input  logic       ready,
  output logic       valid,
  output logic [3:0] digit_val,
  output logic [1:0] digit_idx,
  output logic       pat_err,
  output logic       overrun,
  output logic       page
);
  import seg7_pkg::*;

  localparam logic [3:0] STABLE_W = 4'(STABLE_CYCLES);

  // Sample path: {dig_sel, seg} as 11 bits
  logic [6:0]  w_seg;
  logic [10:0] r_sample;
  logic [10:0] r_prev;
  logic [10:0] r_cap;

  // FSM
  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [3:0]  w_cnt_inc;
  logic        w_cap_en;

  // Derived conditions
  logic        w_sample_one_hot;
  logic        w_same_prev;
  logic        w_same_cap;

  // Decoded captured pattern
  logic [3:0]  w_dec_val;
  logic        w_dec_err;
  logic [1:0]  w_cap_idx;

  // Output datapath control
  logic        w_load;
  logic        w_drop;

  // Output registers
  logic        r_valid;
  logic [3:0]  r_digit_val;
  logic [1:0]  r_digit_idx;
  logic        r_pat_err;
  logic        r_overrun;
  logic        r_page;

`ifdef SEG7_RD_ACTIVE_LOW_EN
  assign w_seg = ~seg_in;
`else
  assign w_seg = seg_in;
`endif

  assign w_sample_one_hot = is_one_hot(r_sample[10:7]);
  assign w_same_prev      = (r_sample == r_prev);
  assign w_same_cap       = (r_sample == r_cap);
  assign w_cnt_inc        = (r_cnt == 4'hF) ? r_cnt : (r_cnt + 4'd1);
  assign w_cap_idx        = one_hot_idx(r_cap[10:7]);

  seg7_pattern_dec u_dec (
    .i_pattern (r_cap[6:0]),
    .o_value   (w_dec_val),
    .o_err     (w_dec_err)
  );

  // Register the raw inputs and keep the previous sample for stability checks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample <= 11'd0;
      r_prev   <= 11'd0;
    end else begin
      r_sample <= {dig_sel, w_seg};
      r_prev   <= r_sample;
    end
  end

  // FSM state, stability counter and captured-sample register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_cap   <= 11'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_cap_en) begin
        r_cap <= r_sample;
      end
    end
  end

  // Next-state logic: settle on a stable one-hot sample, capture once, hold
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cap_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sample_one_hot) begin
          w_state_next = ST_SETTLE;
          w_cnt_next   = 4'd1;
        end else begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 4'd0;
        end
      end
      ST_SETTLE: begin
        if (!w_sample_one_hot) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 4'd0;
        end else if (w_same_prev) begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc >= STABLE_W) begin
            // The settled sample is frozen here so CAPTURE decodes exactly it
            w_state_next = ST_CAPTURE;
            w_cap_en     = 1'b1;
          end else begin
            w_state_next = ST_SETTLE;
          end
        end else begin
          w_state_next = ST_SETTLE;
          w_cnt_next   = 4'd1;
        end
      end
      ST_CAPTURE: begin
        w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_same_cap) begin
          w_state_next = ST_HOLD;
        end else begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 4'd0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // Capture is accepted when the output slot is free or being emptied now
  always_comb begin
    w_load = 1'b0;
    w_drop = 1'b0;
    if (r_state == ST_CAPTURE) begin
      w_load = !r_valid || ready;
      w_drop = r_valid && !ready;
    end else begin
      w_load = 1'b0;
      w_drop = 1'b0;
    end
  end

  // Output registers: handshake, captured digit, sticky overrun, page flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_digit_val <= 4'd0;
      r_digit_idx <= 2'd0;
      r_pat_err   <= 1'b0;
      r_overrun   <= 1'b0;
      r_page      <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid     <= 1'b1;
        r_digit_val <= w_dec_val;
        r_digit_idx <= w_cap_idx;
        r_pat_err   <= w_dec_err;
        if (w_cap_idx == 2'd0) begin
          if (w_dec_val == 4'd1) begin
            r_page <= 1'b0;
          end else if (w_dec_val == 4'd2) begin
            r_page <= 1'b1;
          end
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign valid     = r_valid;
  assign digit_val = r_digit_val;
  assign digit_idx = r_digit_idx;
  assign pat_err   = r_pat_err;
  assign overrun   = r_overrun;
  assign page      = r_page;

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before capture (legal range 2..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port seg_in  input  7  segment lines {a,b,c,d,e,f,g}, a = MSB, a top then clockwise, g middle; active-high.
REQ-005 SHALL have port dig_sel  input  4  one-hot digit strobe of a multiplexed display; bit n selects digit n.
REQ-006 SHALL have port ready  input  1  consumer accepts the current capture.
REQ-007 SHALL have port valid  output  1  capture available.
REQ-008 SHALL have port digit_val  output  4  decoded BCD value, 4'hF if pattern unrecognised.
REQ-009 SHALL have port digit_idx  output  2  index of the one-hot dig_sel bit captured.
REQ-010 SHALL have port pat_err  output  1  capture held an unrecognised pattern.
REQ-011 SHALL have port overrun  output  1  sticky: a capture was dropped because valid was held.
REQ-012 SHALL have port page  output  1  page flag: digit 0 reading 1 -> 0, reading 2 -> 1.

Function
REQ-013 SHALL register {dig_sel, seg_in} once per cycle into a sample register before any other use.
REQ-014 SHALL run FSM IDLE -> SETTLE -> CAPTURE -> HOLD -> IDLE.
REQ-015 IDLE: leave on a one-hot sample, entering SETTLE with stability counter = 1.
REQ-016 SETTLE: increment counter while sample equals previous sample; on any difference restart counter at 1; on non-one-hot sample return to IDLE.
REQ-017 SETTLE -> CAPTURE when counter reaches STABLE_CYCLES; valid rises STABLE_CYCLES+1 cycles after the input change.
REQ-018 CAPTURE lasts one cycle and loads digit_val, digit_idx, pat_err, then enters HOLD.
REQ-019 HOLD: stay while sample equals the captured sample; any change returns to IDLE, so each digit presentation yields exactly one capture.
REQ-020 Decode: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9; 1110011 also =9; all else -> 4'hF with pat_err = 1.
REQ-021 valid SHALL stay high with outputs stable until a cycle with ready = 1, then clear.
REQ-022 CAPTURE with valid = 1 and ready = 0: new data dropped, overrun set; overrun clears only on reset.
REQ-023 CAPTURE with valid = 1 and ready = 1 in the same cycle: new data loaded, valid stays high, no overrun.
REQ-024 On capture with digit_idx = 0: digit_val 1 sets page = 0, 2 sets page = 1, other values leave page unchanged.
REQ-025 Counter SHALL be 4 bits; it saturates and never wraps.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, sample register 0, valid 0, digit_val 0, digit_idx 0, pat_err 0, overrun 0, page 0, immediately and regardless of clk.
REQ-027 Reset mid-SETTLE or mid-HOLD SHALL discard the partial capture; after release the FSM restarts from IDLE.

Configuration
REQ-028 Macro SEG7_RD_ACTIVE_LOW_EN defined: seg_in inverted before the sample register (common-anode panels), all other behaviour identical.
REQ-029 Macro absent: seg_in used as active-high.

Structure
REQ-030 Package seg7_pkg SHALL hold the ten segment pattern constants, the alternate 9 pattern, the FSM state enum and the 4'hF error code.
REQ-031 Pattern lookup SHALL be the combinational sub-module seg7_pattern_dec (7-bit in, 4-bit value plus error out), reusable by the display side.

Verification
REQ-032 dig_sel=0001, seg_in=0110000 held 10 cycles, ready=1 -> one capture: valid high cycle 5 after change, digit_val=1, digit_idx=0, page=0.
REQ-033 dig_sel=0001, seg_in=1101101 held, ready=1 -> digit_val=2, page=1; then dig_sel=0100, seg_in=1111011 -> digit_val=9, digit_idx=2, page unchanged at 1.
REQ-034 seg_in toggles every 3 cycles with STABLE_CYCLES=4 -> valid never asserts.
REQ-035 ready=0, two digit presentations -> first capture held, overrun=1, second data dropped; ready pulse then clears valid.
REQ-036 seg_in=1000001 held -> digit_val=4'hF, pat_err=1; dig_sel=0011 held -> no capture.
REQ-037 rst pulsed mid-SETTLE after 2 stable cycles -> all outputs 0 at once; after release full STABLE_CYCLES+1 latency again; with SEG7_RD_ACTIVE_LOW_EN, seg_in=1001111 decodes to 1.
